// File: rtl/step_ramp_gen.sv
// step_ramp_gen: trapezoidal step-rate generator for a stepper motor.
// Each step toggles rotate_pulse. Step periods shrink from period_start
// toward period_min by accel_delta per step, cruise at period_min, then
// grow back symmetrically so the move ends at period_start.
module step_ramp_gen #(
    parameter int STEP_W = 16,
    parameter int PER_W  = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              abort,
    input  logic              dir_in,
    input  logic [STEP_W-1:0] step_count,
    input  logic [PER_W-1:0]  period_start,
    input  logic [PER_W-1:0]  period_min,
    input  logic [PER_W-1:0]  accel_delta,
    output logic              rotate_pulse,
    output logic              direction,
    output logic              busy,
    output logic              done,
    output logic [STEP_W-1:0] steps_done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCEL  = 2'd1,
        CRUISE = 2'd2,
        DECEL  = 2'd3
    } state_t;

    state_t state_q, state_d;

    // Move parameters latched on start, and the running move state
    logic              dir_q,        dir_d;
    logic [STEP_W-1:0] rem_q,        rem_d;         // steps still to issue
    logic [STEP_W-1:0] ramp_q,       ramp_d;        // steps taken while accelerating
    logic [STEP_W-1:0] steps_done_q, steps_done_d;
    logic [PER_W-1:0]  per_cur_q,    per_cur_d;     // period of the step in progress
    logic [PER_W-1:0]  per_start_q,  per_start_d;
    logic [PER_W-1:0]  per_min_q,    per_min_d;
    logic [PER_W-1:0]  delta_q,      delta_d;
    logic [PER_W-1:0]  el_q,         el_d;          // cycles elapsed since last toggle
    logic              rot_q,        rot_d;
    logic              done_q,       done_d;

    // Combinational helpers
    logic [PER_W-1:0]  eff_min;
    logic [PER_W-1:0]  eff_start;
    logic [PER_W:0]    el_inc;
    logic              tick;
    logic [PER_W-1:0]  acc_per;
    logic [STEP_W-1:0] rem_new;
    logic [STEP_W-1:0] ramp_new;
    logic [STEP_W-1:0] stop_rem;

    // Periods below 2 cycles cannot be produced by the counter; clamp them.
    function automatic logic [PER_W-1:0] clamp_min2(input logic [PER_W-1:0] p);
        return (p < PER_W'(2)) ? PER_W'(2) : p;
    endfunction

    // Saturating p - d, never below lo.
    function automatic logic [PER_W-1:0] ramp_down(input logic [PER_W-1:0] p,
                                                   input logic [PER_W-1:0] d,
                                                   input logic [PER_W-1:0] lo);
        logic [PER_W-1:0] s;
        s = (p > d) ? (p - d) : '0;
        return (s < lo) ? lo : s;
    endfunction

    // Saturating p + d, never above hi.
    function automatic logic [PER_W-1:0] ramp_up(input logic [PER_W-1:0] p,
                                                 input logic [PER_W-1:0] d,
                                                 input logic [PER_W-1:0] hi);
        logic [PER_W:0] s;
        s = {1'b0, p} + {1'b0, d};
        return (s > {1'b0, hi}) ? hi : s[PER_W-1:0];
    endfunction

    // Effective periods to latch: both at least 2, start never faster than cruise
    always_comb begin
        eff_min   = clamp_min2(period_min);
        eff_start = clamp_min2(period_start);
        if (eff_start < eff_min) begin
            eff_start = eff_min;
        end
    end

    // Period counter compare and per-step arithmetic
    always_comb begin
        el_inc   = {1'b0, el_q} + (PER_W+1)'(1);
        tick     = (el_inc >= {1'b0, per_cur_q});
        acc_per  = ramp_down(per_cur_q, delta_q, per_min_q);
        rem_new  = rem_q - STEP_W'(1);
        ramp_new = ramp_q + STEP_W'(1);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and next-datapath logic
    always_comb begin
        state_d      = state_q;
        dir_d        = dir_q;
        rem_d        = rem_q;
        ramp_d       = ramp_q;
        steps_done_d = steps_done_q;
        per_cur_d    = per_cur_q;
        per_start_d  = per_start_q;
        per_min_d    = per_min_q;
        delta_d      = delta_q;
        el_d         = el_q;
        rot_d        = rot_q;
        done_d       = 1'b0;
        stop_rem     = '0;

        if (state_q == IDLE) begin
            // abort in IDLE does nothing itself but still masks a start
            if (start && !abort) begin
                if (step_count != '0) begin
                    state_d      = ACCEL;
                    dir_d        = dir_in;
                    rem_d        = step_count;
                    ramp_d       = '0;
                    steps_done_d = '0;
                    per_start_d  = eff_start;
                    per_min_d    = eff_min;
                    delta_d      = accel_delta;
                    per_cur_d    = eff_start;
                    el_d         = '0;
                end else begin
                    done_d = 1'b1;
                end
            end
        end else if (abort) begin
            // Immediate halt: no toggle on this edge and no done pulse
            state_d = IDLE;
            el_d    = '0;
        end else begin
            if (tick) begin
                el_d         = '0;
                rot_d        = ~rot_q;
                steps_done_d = steps_done_q + STEP_W'(1);
                rem_d        = rem_new;
                if (rem_new == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    case (state_q)
                        ACCEL: begin
                            ramp_d = ramp_new;
                            if (rem_new <= ramp_new) begin
                                // Mirror point reached mid-ramp: repeat the last
                                // accel period, then climb back out.
                                state_d = DECEL;
                            end else begin
                                per_cur_d = acc_per;
                                if (acc_per == per_min_q) begin
                                    state_d = CRUISE;
                                end
                            end
                        end
                        CRUISE: begin
                            if (rem_new <= ramp_q) begin
                                state_d   = DECEL;
                                per_cur_d = ramp_up(per_cur_q, delta_q, per_start_q);
                            end
                        end
                        default: begin
                            per_cur_d = ramp_up(per_cur_q, delta_q, per_start_q);
                        end
                    endcase
                end
            end else begin
                el_d = el_q + PER_W'(1);
                // No ramp possible (already at cruise, or zero delta)
                if (state_q == ACCEL && (per_cur_q == per_min_q || delta_q == '0)) begin
                    state_d = CRUISE;
                end
            end

            // Controlled stop: shorten the move to a mirror of the ramp so far
            if (stop && (state_d == ACCEL || state_d == CRUISE)) begin
                stop_rem = (rem_d < ramp_d) ? rem_d : ramp_d;
                if (stop_rem == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    rem_d     = stop_rem;
                    state_d   = DECEL;
                    per_cur_d = ramp_up(per_cur_d, delta_q, per_start_q);
                end
            end
        end
    end

    // Datapath and latched-parameter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir_q        <= 1'b0;
            rem_q        <= '0;
            ramp_q       <= '0;
            steps_done_q <= '0;
            per_cur_q    <= '0;
            per_start_q  <= '0;
            per_min_q    <= '0;
            delta_q      <= '0;
            el_q         <= '0;
            rot_q        <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            dir_q        <= dir_d;
            rem_q        <= rem_d;
            ramp_q       <= ramp_d;
            steps_done_q <= steps_done_d;
            per_cur_q    <= per_cur_d;
            per_start_q  <= per_start_d;
            per_min_q    <= per_min_d;
            delta_q      <= delta_d;
            el_q         <= el_d;
            rot_q        <= rot_d;
            done_q       <= done_d;
        end
    end

    // Outputs
    always_comb begin
        rotate_pulse = rot_q;
        direction    = dir_q;
        busy         = (state_q != IDLE);
        done         = done_q;
        steps_done   = steps_done_q;
    end

endmodule

// File: tb/tb_step_ramp_gen.sv
// Directed testbench for step_ramp_gen: step timing, ramp profiles,
// stop/abort/reset behaviour and start handling.
module tb_step_ramp_gen;

    localparam int STEP_W = 16;
    localparam int PER_W  = 24;

    typedef int prof_t [10];

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic              abort = 1'b0;
    logic              dir_in = 1'b0;
    logic [STEP_W-1:0] step_count = '0;
    logic [PER_W-1:0]  period_start = '0;
    logic [PER_W-1:0]  period_min = '0;
    logic [PER_W-1:0]  accel_delta = '0;
    logic              rotate_pulse;
    logic              direction;
    logic              busy;
    logic              done;
    logic [STEP_W-1:0] steps_done;

    int passed = 0;
    int total  = 0;
    int failed = 0;

    step_ramp_gen #(.STEP_W(STEP_W), .PER_W(PER_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .stop         (stop),
        .abort        (abort),
        .dir_in       (dir_in),
        .step_count   (step_count),
        .period_start (period_start),
        .period_min   (period_min),
        .accel_delta  (accel_delta),
        .rotate_pulse (rotate_pulse),
        .direction    (direction),
        .busy         (busy),
        .done         (done),
        .steps_done   (steps_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: edge numbers of toggles, move start edge, done/busy counts
    int   tog_cyc[$];
    int   start_cyc = 0;
    int   done_cnt = 0;
    int   busy_cnt = 0;
    logic rot_prev = 1'b0;
    logic busy_prev = 1'b0;
    always @(posedge clk) begin
        #1;
        if (rotate_pulse !== rot_prev) tog_cyc.push_back(cyc);
        if (busy && !busy_prev) start_cyc = cyc;
        if (busy) busy_cnt++;
        if (done) done_cnt++;
        rot_prev  = rotate_pulse;
        busy_prev = busy;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            failed++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clr_mon();
        tog_cyc.delete();
        done_cnt = 0;
        busy_cnt = 0;
    endtask

    function automatic int per_at(input int i);
        if (i >= tog_cyc.size()) return -1;
        return (i == 0) ? (tog_cyc[0] - start_cyc) : (tog_cyc[i] - tog_cyc[i-1]);
    endfunction

    task automatic go(input int n, input int ps, input int pm, input int d, input logic dr);
        @(negedge clk);
        clr_mon();
        step_count   = STEP_W'(n);
        period_start = PER_W'(ps);
        period_min   = PER_W'(pm);
        accel_delta  = PER_W'(d);
        dir_in       = dr;
        start        = 1'b1;
        @(negedge clk);
        start        = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (busy && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_idle"}, busy, 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_tog(input int n, input string tag);
        int k = 0;
        while (tog_cyc.size() < n && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_reach"}, (tog_cyc.size() >= n), 1);
    endtask

    task automatic check_prof(input string tag, input int n, input prof_t e);
        check({tag, "_ntog"}, tog_cyc.size(), n);
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_per%0d", tag, i), per_at(i), e[i]);
        end
    endtask

    initial begin
        // Reset state
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_rot", rotate_pulse, 0);
        check("rst_dir", direction, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_steps", steps_done, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Constant period, with a start attempt and input changes mid-move
        go(5, 10, 10, 0, 1'b1);
        repeat (14) @(negedge clk);
        step_count   = 16'd3;
        period_start = 24'd3;
        dir_in       = 1'b0;
        start        = 1'b1;
        @(negedge clk);
        start        = 1'b0;
        wait_idle("const");
        check_prof("const", 5, '{10, 10, 10, 10, 10, 0, 0, 0, 0, 0});
        check("const_steps", steps_done, 5);
        check("const_done", done_cnt, 1);
        check("const_busy", busy_cnt, 50);
        check("const_dir", direction, 1);
        check("const_rot", rotate_pulse, 1);

        // Full trapezoid
        go(10, 40, 10, 10, 1'b0);
        wait_idle("trap");
        check_prof("trap", 10, '{40, 30, 20, 10, 10, 10, 10, 20, 30, 40});
        check("trap_steps", steps_done, 10);
        check("trap_done", done_cnt, 1);
        check("trap_dir", direction, 0);

        // Short move: triangle, cruise never reached
        go(4, 40, 10, 10, 1'b1);
        wait_idle("tri");
        check_prof("tri", 4, '{40, 30, 30, 40, 0, 0, 0, 0, 0, 0});
        check("tri_steps", steps_done, 4);
        check("tri_done", done_cnt, 1);

        // Controlled stop after the 5th toggle; a stop while decelerating is ignored
        go(10, 40, 10, 10, 1'b1);
        wait_tog(5, "stop");
        repeat (2) @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        wait_tog(6, "stop6");
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        wait_idle("stop");
        check_prof("stop", 8, '{40, 30, 20, 10, 10, 20, 30, 40, 0, 0});
        check("stop_steps", steps_done, 8);
        check("stop_done", done_cnt, 1);

        // Abort after the 3rd toggle
        go(10, 40, 10, 10, 1'b1);
        wait_tog(3, "abort");
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        repeat (100) @(negedge clk);
        check("abort_ntog", tog_cyc.size(), 3);
        check("abort_done", done_cnt, 0);
        check("abort_busy", busy, 0);
        check("abort_steps", steps_done, 3);

        // Reset mid-move after the 3rd toggle
        go(10, 40, 10, 10, 1'b1);
        wait_tog(3, "mrst");
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        clr_mon();
        check("mrst_busy", busy, 0);
        check("mrst_steps", steps_done, 0);
        check("mrst_rot", rotate_pulse, 0);
        check("mrst_dir", direction, 0);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        check("mrst_ntog", tog_cyc.size(), 0);
        check("mrst_done", done_cnt, 0);
        check("mrst_busy_after", busy, 0);

        // Zero-length move: done one cycle later, no toggle, never busy
        @(negedge clk);
        clr_mon();
        step_count = '0;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        check("zero_done", done, 1);
        check("zero_busy", busy, 0);
        @(negedge clk);
        check("zero_done_drop", done, 0);
        check("zero_ntog", tog_cyc.size(), 0);
        check("zero_done_cnt", done_cnt, 1);

        // abort masks a simultaneous start
        @(negedge clk);
        clr_mon();
        step_count = 16'd5;
        start      = 1'b1;
        abort      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        abort      = 1'b0;
        repeat (3) @(negedge clk);
        check("abst_busy_cnt", busy_cnt, 0);
        check("abst_ntog", tog_cyc.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/step_ramp_gen.md
STEP_RAMP_GEN -- requirements
Module: step_ramp_gen

Interface
REQ-001 The block SHALL have parameter STEP_W, default 16, giving the step-count width.
REQ-002 The block SHALL have parameter PER_W, default 24, giving the step-period width in clk cycles.
REQ-003 Port clk, input, 1, is the single clock; all state changes on its rising edge.
REQ-004 Port rst_n, input, 1, is the reset: asynchronous assert, active-low.
REQ-005 Port start, input, 1, requests a move while high for one cycle.
REQ-006 Port stop, input, 1, requests a controlled deceleration to halt.
REQ-007 Port abort, input, 1, requests an immediate halt.
REQ-008 Port dir_in, input, 1, gives the requested direction and is sampled on start.
REQ-009 Port step_count, input, STEP_W, gives the number of steps in the move.
REQ-010 Port period_start, input, PER_W, gives the first and last step period.
REQ-011 Port period_min, input, PER_W, gives the cruise step period.
REQ-012 Port accel_delta, input, PER_W, gives the period change per step while ramping.
REQ-013 Port rotate_pulse, output, 1, toggles once per step and feeds the motor phase modules' rotate_pulse input.
REQ-014 Port direction, output, 1, gives the latched direction for the motor modules.
REQ-015 Port busy, output, 1, is high while a move is in progress.
REQ-016 Port done, output, 1, is a one-cycle pulse when a move completes or is stopped.
REQ-017 Port steps_done, output, STEP_W, counts the steps issued in the current or last move.

Function
REQ-018 The FSM SHALL have states IDLE, ACCEL, CRUISE and DECEL; busy SHALL be 1 in every state except IDLE.
REQ-019 start in IDLE with step_count != 0 SHALL:
- latch dir_in, step_count, both periods and accel_delta
- clear steps_done and set period_cur = period_start
- enter ACCEL; busy rises on the next edge
REQ-020 start in IDLE with step_count == 0 SHALL produce a done pulse on the next cycle, with no toggle and busy staying low.
REQ-021 start while busy SHALL be ignored, and inputs changing mid-move SHALL have no effect.
REQ-022 Any latched period below 2 SHALL be treated as 2, and a latched period_start below period_min SHALL be treated as period_min.
REQ-023 A period counter SHALL toggle rotate_pulse exactly period_cur cycles after the previous toggle, or after the start-accept edge for the first step.
REQ-024 On each toggle the block SHALL increment steps_done and decrement the remaining-step count.
REQ-025 In ACCEL, after each step, period_cur SHALL become max(period_cur - accel_delta, period_min) using saturating arithmetic, and the ramp-step count SHALL increment.
REQ-026 ACCEL SHALL go to CRUISE when period_cur == period_min.
REQ-027 ACCEL or CRUISE SHALL go to DECEL when remaining steps <= ramp steps, so that the profile is symmetric.
REQ-028 In DECEL, after each step, period_cur SHALL become min(period_cur + accel_delta, period_start).
REQ-029 When remaining steps reach 0, the block SHALL enter IDLE on the cycle after the last toggle, pulse done for one cycle and drop busy.
REQ-030 accel_delta == 0 SHALL give a constant period of period_start, with ACCEL going directly to CRUISE.
REQ-031 stop in ACCEL or CRUISE SHALL set remaining = min(remaining, ramp steps) and enter DECEL; stop in DECEL or IDLE SHALL have no effect.
REQ-032 abort in any busy state SHALL return to IDLE on the next edge with no further toggles and no done pulse.
REQ-033 abort in IDLE SHALL have no effect.
REQ-034 abort SHALL win over simultaneous stop or start.
REQ-035 rotate_pulse SHALL hold its level while idle; toggle parity is not reset between moves.
REQ-036 steps_done SHALL hold its final value in IDLE until the next accepted start.

Reset
REQ-037 rst_n low SHALL asynchronously force:
- state IDLE
- rotate_pulse, direction, busy, done and steps_done to 0
- all counters and latched parameters to 0
REQ-038 Reset asserted mid-move SHALL abandon the move with no done pulse; operation resumes on the first clk edge after rst_n deasserts.

Verification
REQ-039 The bench SHALL check: step_count=5, period_start=period_min=10, accel_delta=0 -> 5 toggles exactly 10 cycles apart, steps_done=5, a single done pulse, busy high for 50 cycles.
REQ-040 The bench SHALL check: step_count=10, period_start=40, period_min=10, accel_delta=10 -> periods 40,30,20,10,10,10,10,20,30,40.
REQ-041 The bench SHALL check: step_count=4 with the REQ-040 ramp settings -> periods 40,30,30,40, with no CRUISE reached.
REQ-042 The bench SHALL check: the REQ-040 setup with stop after the 5th toggle -> further periods 20,30,40, steps_done=8, then done.
REQ-043 The bench SHALL check: abort or rst_n low after the 3rd toggle -> no further toggles, no done pulse, busy low, with rst_n also clearing steps_done to 0.
REQ-044 The bench SHALL check: start with step_count=0 -> done one cycle later and no toggle; start while busy -> ignored.
